// File: rtl/toggle_activity_monitor.sv
// Switching-activity monitor: counts bus toggles and peak per-cycle toggles per window.
// Report registered on the last counted edge; a pending unaccepted report drops new windows (sticky flag).
module toggle_activity_monitor #(
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 16,
   parameter int WINDOW = 256,
   parameter int PK_W   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             start,
   input  logic [WIDTH-1:0] sig,
   output logic [CNT_W-1:0] toggles,
   output logic [PK_W-1:0]  peak,
   output logic             report_valid,
   input  logic             report_ready,
   output logic             dropped,
   output logic             busy
);

   localparam int SW   = ((CNT_W > PK_W) ? CNT_W : PK_W) + 1;
   localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [SW-1:0] CAP = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, PRIME, COUNT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] diff;
   logic [PK_W-1:0]  act;
   logic [PK_W-1:0]  pk;
   logic [PK_W-1:0]  pk_nxt;
   logic [CNT_W-1:0] accum;
   logic [CNT_W-1:0] accum_nxt;
   logic [SW-1:0]    sum;
   logic [WC_W-1:0]  wcnt;
   logic             last;
   logic             accept;

   always_comb begin
      diff = sig ^ sig_q;
      act  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         act = act + PK_W'(diff[i]);
      end
   end

   // Sum is one bit wider than either operand so saturation never misses a carry.
   assign sum       = SW'(accum) + SW'(act);
   assign accum_nxt = (sum > CAP) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   assign pk_nxt    = (act > pk) ? act : pk;
   assign last      = (wcnt == WC_W'(WINDOW - 1));
   assign accept    = report_valid && report_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         sig_q        <= '0;
         accum        <= '0;
         pk           <= '0;
         wcnt         <= '0;
         toggles      <= '0;
         peak         <= '0;
         report_valid <= 1'b0;
         dropped      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         sig_q <= sig;
         if (accept) begin
            report_valid <= 1'b0;
         end
         if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            accum <= '0;
            pk    <= '0;
            wcnt  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (!mode || start) begin
                     state <= PRIME;
                     busy  <= 1'b1;
                  end
               end
               PRIME: begin
                  state <= COUNT;
               end
               COUNT: begin
                  if (last) begin
                     accum <= '0;
                     pk    <= '0;
                     wcnt  <= '0;
                     // A same-edge accept frees the slot, so the new window may load.
                     if (!report_valid || accept) begin
                        toggles      <= accum_nxt;
                        peak         <= pk_nxt;
                        report_valid <= 1'b1;
                     end else begin
                        dropped <= 1'b1;
                     end
                     if (mode) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     accum <= accum_nxt;
                     pk    <= pk_nxt;
                     wcnt  <= wcnt + WC_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: table-driven single-shot windows, random windows vs a sample-history model,
// plus hand sequences for drop, same-edge reload, asynchronous reset and enable abort.
module tb_toggle_activity_monitor;

   localparam int W = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       mode;
   logic       start;
   logic [7:0] sig;
   logic       report_ready;

   logic [15:0] toggles;
   logic [3:0]  peak;
   logic        report_valid;
   logic        dropped;
   logic        busy;

   logic [5:0]  toggles6;
   logic [3:0]  peak6;
   logic        report_valid6;
   logic        dropped6;
   logic        busy6;

   toggle_activity_monitor #(.WIDTH(8), .CNT_W(16), .WINDOW(W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start), .sig(sig),
      .toggles(toggles), .peak(peak), .report_valid(report_valid), .report_ready(report_ready),
      .dropped(dropped), .busy(busy)
   );

   toggle_activity_monitor #(.WIDTH(8), .CNT_W(6), .WINDOW(W)) dut6 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start), .sig(sig),
      .toggles(toggles6), .peak(peak6), .report_valid(report_valid6), .report_ready(report_ready),
      .dropped(dropped6), .busy(busy6)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Value of sig sampled at each edge, indexed from the edge that starts the run.
   logic [7:0] s [0:255];
   int         n;

   typedef struct {
      int pat;
      int tog;
      int pk;
      int tog6;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gen(input int pat, input int k);
      logic [7:0] kb;
      kb = k[7:0];
      case (pat)
         0:       return kb[0] ? 8'hFF : 8'h00;
         1:       return 8'hA5;
         2:       return 8'hA5 ^ {7'b0, kb[0]};
         3:       return kb[0] ? 8'hF0 : 8'h0F;
         4:       return kb;
         default: return 8'($urandom);
      endcase
   endfunction

   // Window after edge 'base' compares samples base+1 .. base+W+1.
   function automatic int model_tog(input int base, input int cap);
      int t = 0;
      for (int j = 1; j <= W; j++) t += $countones(s[base+j] ^ s[base+j+1]);
      return (t > cap) ? cap : t;
   endfunction

   function automatic int model_pk(input int base);
      int p = 0;
      for (int j = 1; j <= W; j++) begin
         if ($countones(s[base+j] ^ s[base+j+1]) > p) p = $countones(s[base+j] ^ s[base+j+1]);
      end
      return p;
   endfunction

   task automatic step(input logic [7:0] v);
      sig = v;
      @(posedge clk);
      s[n] = v;
      n++;
      #1;
   endtask

   // Single-shot run: start edge E0, then edges E1..E(W+1).
   task automatic run_single(input int pat, input string name);
      mode  = 1'b1;
      enable = 1'b1;
      start = 1'b1;
      n = 0;
      step(gen(pat, 0));
      start = 1'b0;
      chk({name, "_busy_e0"}, int'(busy), 1);
      for (int k = 1; k <= W; k++) step(gen(pat, k));
      chk({name, "_valid_early"}, int'(report_valid), 0);
      step(gen(pat, W + 1));
      chk({name, "_valid"}, int'(report_valid), 1);
      chk({name, "_busy_end"}, int'(busy), 0);
   endtask

   task automatic accept_report(input string name);
      report_ready = 1'b1;
      step(sig);
      report_ready = 1'b0;
      chk({name, "_valid_after_accept"}, int'(report_valid), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_v;
      bit seen_b;

      tbl[0] = '{pat: 1, tog: 0,   pk: 0, tog6: 0};
      tbl[1] = '{pat: 2, tog: 16,  pk: 1, tog6: 16};
      tbl[2] = '{pat: 0, tog: 128, pk: 8, tog6: 63};
      tbl[3] = '{pat: 3, tog: 128, pk: 8, tog6: 63};
      tbl[4] = '{pat: 4, tog: 31,  pk: 5, tog6: 31};

      reset = 1'b1; enable = 1'b0; mode = 1'b1; start = 1'b0; sig = 8'h00; report_ready = 1'b0; n = 0;
      #2;
      chk("rst_toggles", int'(toggles), 0);
      chk("rst_peak", int'(peak), 0);
      chk("rst_valid", int'(report_valid), 0);
      chk("rst_dropped", int'(dropped), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Table: first entry runs straight after reset with sig_q=0 and sig nonzero.
      for (int i = 0; i < 5; i++) begin
         string nm;
         nm = $sformatf("tbl%0d", i);
         run_single(tbl[i].pat, nm);
         chk({nm, "_toggles"}, int'(toggles), tbl[i].tog);
         chk({nm, "_peak"}, int'(peak), tbl[i].pk);
         chk({nm, "_toggles_cnt6"}, int'(toggles6), tbl[i].tog6);
         chk({nm, "_peak_cnt6"}, int'(peak6), tbl[i].pk);
         accept_report(nm);
      end

      // Enable dropped while wcnt==5: abort, keep last report (31/5).
      mode = 1'b1; enable = 1'b1; start = 1'b1; n = 0;
      step(8'h00);
      start = 1'b0;
      for (int k = 1; k <= 6; k++) step(gen(0, k));
      enable = 1'b0;
      step(8'h55);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(report_valid), 0);
      chk("abort_toggles", int'(toggles), 31);
      chk("abort_peak", int'(peak), 5);
      enable = 1'b1;
      seen_v = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(gen(0, k));
         if (report_valid) seen_v = 1'b1;
      end
      chk("abort_no_report", int'(seen_v), 0);

      // Random single-shot windows.
      for (int r = 0; r < 4; r++) begin
         string nm;
         nm = $sformatf("rnd%0d", r);
         run_single(5, nm);
         chk({nm, "_toggles"}, int'(toggles), model_tog(0, 65535));
         chk({nm, "_peak"}, int'(peak), model_pk(0));
         chk({nm, "_toggles_cnt6"}, int'(toggles6), model_tog(0, 63));
         accept_report(nm);
      end

      // Continuous random windows, consumer always ready.
      mode = 1'b0; enable = 1'b1; report_ready = 1'b1; n = 0;
      step(8'($urandom));
      for (int k = 1; k <= 3 * W + 1; k++) begin
         step(8'($urandom));
         if (k > W && ((k - 1) % W) == 0) begin
            chk($sformatf("cont_valid_e%0d", k), int'(report_valid), 1);
            chk($sformatf("cont_toggles_e%0d", k), int'(toggles), model_tog(k - W - 1, 65535));
            chk($sformatf("cont_peak_e%0d", k), int'(peak), model_pk(k - W - 1));
         end
      end
      enable = 1'b0;
      step(8'h00);
      step(8'h00);
      report_ready = 1'b0;
      chk("cont_idle_valid", int'(report_valid), 0);

      // Continuous, consumer stalled: first report held, second window dropped.
      mode = 1'b0; enable = 1'b1; report_ready = 1'b0; n = 0;
      step(gen(0, 0));
      for (int k = 1; k <= 48; k++) begin
         step(k <= W + 1 ? gen(0, k) : gen(5, k));
         if (k == W + 1) begin
            chk("stall_valid1", int'(report_valid), 1);
            chk("stall_toggles1", int'(toggles), 128);
            chk("stall_peak1", int'(peak), 8);
            chk("stall_dropped1", int'(dropped), 0);
         end
         if (k == 2 * W + 1) begin
            chk("stall_dropped2", int'(dropped), 1);
            chk("stall_toggles2", int'(toggles), 128);
            chk("stall_peak2", int'(peak), 8);
            chk("stall_valid2", int'(report_valid), 1);
         end
      end
      // Ready asserted exactly on the third window-end edge.
      report_ready = 1'b1;
      step(8'($urandom));
      report_ready = 1'b0;
      chk("reload_valid", int'(report_valid), 1);
      chk("reload_toggles", int'(toggles), model_tog(2 * W, 65535));
      chk("reload_peak", int'(peak), model_pk(2 * W));
      step(8'($urandom));
      chk("reload_valid_hold", int'(report_valid), 1);
      chk("reload_dropped_sticky", int'(dropped), 1);

      // Asynchronous reset mid-window with report pending.
      for (int k = 0; k < 5; k++) step(8'($urandom));
      #2;
      reset = 1'b1;
      #1;
      chk("arst_toggles", int'(toggles), 0);
      chk("arst_peak", int'(peak), 0);
      chk("arst_valid", int'(report_valid), 0);
      chk("arst_dropped", int'(dropped), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_cnt6_state", int'({report_valid6, dropped6, busy6}), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      mode = 1'b1; enable = 1'b1; start = 1'b0;
      seen_v = 1'b0;
      seen_b = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step(8'($urandom));
         if (report_valid) seen_v = 1'b1;
         if (busy) seen_b = 1'b1;
      end
      chk("post_rst_no_report", int'(seen_v), 0);
      chk("post_rst_no_busy", int'(seen_b), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
